// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and constants for the pattern source/scorer
package pattern_pkg;

  localparam int         ENTRY_LEN_W       = 8;
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic                   level;
    logic [ENTRY_LEN_W-1:0] len;
  } run_entry_t;

endpackage

// File: rtl/pattern_lfsr8.sv
// rtl/pattern_lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, emits bit 0 first
module pattern_lfsr8
  import pattern_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift right so the seed's own bits come out LSB-first before any feedback bit.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (enable_i) begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/pattern_source_scorer.sv
// rtl/pattern_source_scorer.sv - drives a test bit stream and scores a predictor against it
module pattern_source_scorer
  import pattern_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         LEN_W     = ENTRY_LEN_W,
  parameter int         CNT_W     = 8,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic                     wr_level,
  input  logic [LEN_W-1:0]         wr_len,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic [LEN_W-1:0]         lfsr_len,
  input  logic                     predicted_pattern,
  output logic                     actual_pattern,
  output logic                     pattern_valid,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         x_cnt,
  output logic [CNT_W-1:0]         z_cnt
);

  localparam int               AW      = $clog2(DEPTH);
  localparam int               PW      = AW + 1;
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  run_entry_t       tbl_q [DEPTH];
  run_entry_t       cur;
  logic             mode_q;
  logic [PW-1:0]    n_q, ptr_q, ptr_d;
  logic [LEN_W-1:0] lfsr_len_q, run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] x_q, z_q;
  logic             last_q;
  logic             start_ok, cur_valid, bit_val, last_bit;
  logic             lfsr_bit;
  logic [6:0]       lfsr_unused;

  assign start_ok = start && (state_q != RUN);

  pattern_lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .enable_i(cur_valid && mode_q),
    .load_i  (start_ok),
    .seed_i  (LFSR_SEED),
    .q_o     ({lfsr_unused, lfsr_bit})
  );

  // Current bit and stream bookkeeping; bubbles and idle cycles repeat the last emitted bit.
  always_comb begin
    cur       = tbl_q[ptr_q[AW-1:0]];
    cur_valid = 1'b0;
    bit_val   = last_q;
    last_bit  = 1'b0;
    ptr_d     = ptr_q;
    run_cnt_d = run_cnt_q;
    if (state_q == RUN) begin
      if (mode_q) begin
        cur_valid = (lfsr_len_q != '0);
        if (cur_valid) bit_val = lfsr_bit;
        last_bit  = !cur_valid || (run_cnt_q == lfsr_len_q - LEN_ONE);
        run_cnt_d = run_cnt_q + LEN_ONE;
      end else if (ptr_q >= n_q) begin
        last_bit = 1'b1;
      end else if (cur.len == '0) begin
        ptr_d    = ptr_q + PTR_ONE;
        last_bit = (ptr_d == n_q);
      end else begin
        cur_valid = 1'b1;
        bit_val   = cur.level;
        if (run_cnt_q == cur.len - LEN_ONE) begin
          ptr_d     = ptr_q + PTR_ONE;
          run_cnt_d = '0;
          last_bit  = (ptr_d == n_q);
        end else begin
          run_cnt_d = run_cnt_q + LEN_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pattern_valid  = cur_valid;
    actual_pattern = bit_val;
    busy           = (state_q == RUN);
    done           = (state_q == DONE);
    x_cnt          = x_q;
    z_cnt          = z_q;
  end

  // A write and a start in the same cycle both land on this edge, so the run sees the new entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_en && (state_q != RUN)) begin
      tbl_q[wr_addr] <= {wr_level, wr_len};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= 1'b0;
      n_q        <= '0;
      lfsr_len_q <= '0;
      ptr_q      <= '0;
      run_cnt_q  <= '0;
      x_q        <= '0;
      z_q        <= '0;
      last_q     <= 1'b0;
    end else if (start_ok) begin
      mode_q     <= mode;
      n_q        <= (num_entries > DEPTH_P) ? DEPTH_P : num_entries;
      lfsr_len_q <= lfsr_len;
      ptr_q      <= '0;
      run_cnt_q  <= '0;
      x_q        <= '0;
      z_q        <= '0;
    end else if (state_q == RUN) begin
      ptr_q     <= ptr_d;
      run_cnt_q <= run_cnt_d;
      if (cur_valid) begin
        last_q <= bit_val;
        if (x_q != CNT_MAX) x_q <= x_q + CNT_ONE;
        if ((predicted_pattern == bit_val) && (z_q != CNT_MAX)) z_q <= z_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pattern_source_scorer.sv
// tb/tb_pattern_source_scorer.sv - directed self-checking bench for pattern_source_scorer
module tb_pattern_source_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode, wr_en, wr_level;
  logic [2:0] wr_addr;
  logic [7:0] wr_len, lfsr_len;
  logic [3:0] num_entries;
  logic       predicted_pattern;
  logic       actual_pattern, pattern_valid, busy, done;
  logic [7:0] x_cnt, z_cnt;

  logic       pred_const, pred_dly, prev_act;
  int         n_cmp, n_bad;
  logic       got [64];
  logic       vld [64];
  logic [63:0] gotv, expv;
  int         dcyc, nv;

  int s_lvl [7] = '{0, 1, 0, 1, 0, 1, 0};
  int s_len [7] = '{4, 8, 4, 4, 8, 4, 4};

  always #5 clk = ~clk;

  always @(posedge clk) prev_act <= actual_pattern;
  assign predicted_pattern = pred_dly ? prev_act : pred_const;

  pattern_source_scorer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_level         (wr_level),
    .wr_len           (wr_len),
    .num_entries      (num_entries),
    .lfsr_len         (lfsr_len),
    .predicted_pattern(predicted_pattern),
    .actual_pattern   (actual_pattern),
    .pattern_valid    (pattern_valid),
    .busy             (busy),
    .done             (done),
    .x_cnt            (x_cnt),
    .z_cnt            (z_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int a, input int lvl, input int len);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(a); wr_level = lvl[0]; wr_len = 8'(len);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start a run and watch it until done; inj_c > 0 pulses a write and a start at that cycle.
  task automatic do_run(input logic m, input int budget, input int inj_c);
    @(negedge clk);
    mode = m; start = 1'b1;
    dcyc = -1; nv = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (c < 64) vld[c] = pattern_valid;
      if (pattern_valid) begin
        if (nv < 64) got[nv] = actual_pattern;
        nv++;
      end
      if (done) begin
        dcyc = c;
        break;
      end
      if (c == inj_c) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_level = 1'b0; wr_len = 8'd6; start = 1'b1;
      end
    end
    gotv = '0;
    for (int i = 0; i < 64; i++) if (i < nv) gotv[i] = got[i];
  endtask

  task automatic build_exp(input int skip);
    int k;
    expv = '0;
    k = 0;
    for (int e = 0; e < 7; e++) begin
      if (e != skip) begin
        for (int j = 0; j < s_len[e]; j++) begin
          expv[k] = s_lvl[e][0];
          k++;
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; start = 1'b0; mode = 1'b0; wr_en = 1'b0; wr_level = 1'b0;
    wr_addr = '0; wr_len = '0; num_entries = '0; lfsr_len = '0;
    pred_const = 1'b0; pred_dly = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({actual_pattern, pattern_valid, busy, done, x_cnt, z_cnt}), 64'd0);
    rst = 1'b1;

    for (int e = 0; e < 7; e++) write_entry(e, s_lvl[e], s_len[e]);
    num_entries = 4'd7;

    // Table stream, predictor stuck at 0
    do_run(1'b0, 60, 0);
    build_exp(-1);
    chk("t1_done_cycle", 64'(dcyc), 64'd37);
    chk("t1_valid_bits", 64'(nv), 64'd36);
    chk("t1_sequence", gotv, expv);
    chk("t1_x_cnt", 64'(x_cnt), 64'd36);
    chk("t1_z_cnt", 64'(z_cnt), 64'd20);
    chk("t1_done_state", 64'({pattern_valid, busy, done}), 64'b001);

    // Predictor repeats the previous bit
    pred_dly = 1'b1;
    do_run(1'b0, 60, 0);
    pred_dly = 1'b0;
    chk("t2_x_cnt", 64'(x_cnt), 64'd36);
    chk("t2_z_cnt", 64'(z_cnt), 64'd30);

    // Zero-length entry 1 becomes a bubble
    write_entry(1, 1, 0);
    do_run(1'b0, 60, 0);
    build_exp(1);
    chk("t3_x_cnt", 64'(x_cnt), 64'd28);
    chk("t3_sequence", gotv, expv);
    chk("t3_bubble_valid", 64'({vld[4], vld[5], vld[6]}), 64'b101);
    chk("t3_done_cycle", 64'(dcyc), 64'd30);

    // Empty table
    num_entries = 4'd0;
    do_run(1'b0, 10, 0);
    chk("t4_empty_done", 64'(dcyc), 64'd2);
    chk("t4_empty_x", 64'(x_cnt), 64'd0);

    // LFSR from seed A5
    pred_const = 1'b1; lfsr_len = 8'd10;
    do_run(1'b1, 30, 0);
    chk("t5_lfsr_bits", gotv, 64'h2A5);
    chk("t5_x_cnt", 64'(x_cnt), 64'd10);
    chk("t5_z_cnt", 64'(z_cnt), 64'd5);
    chk("t5_done_cycle", 64'(dcyc), 64'd11);

    // Saturation
    write_entry(0, 1, 255);
    write_entry(1, 1, 255);
    num_entries = 4'd2;
    do_run(1'b0, 600, 0);
    chk("t6_valid_bits", 64'(nv), 64'd510);
    chk("t6_done_cycle", 64'(dcyc), 64'd511);
    chk("t6_sat_counts", 64'({x_cnt, z_cnt}), 64'hFFFF);

    // Reset in the middle of a run
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    begin : wait_bit5
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (x_cnt == 8'd5) disable wait_bit5;
      end
    end
    chk("t7_pre_reset", 64'({busy, x_cnt}), 64'h105);
    rst = 1'b0;
    #1;
    chk("t7_reset_outputs", 64'({actual_pattern, pattern_valid, busy, done, x_cnt, z_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_stays_idle", 64'({busy, done}), 64'd0);

    // Cleared table: two zero-length entries
    do_run(1'b0, 10, 0);
    chk("t8_cleared_table", 64'({8'(dcyc), x_cnt}), 64'h0300);

    // Write with start lands first; write and start during RUN are ignored
    write_entry(0, 1, 3);
    wr_en = 1'b1; wr_addr = 3'd1; wr_level = 1'b0; wr_len = 8'd2;
    pred_const = 1'b0;
    do_run(1'b0, 30, 2);
    chk("t9_sequence", gotv, 64'h07);
    chk("t9_done_cycle", 64'(dcyc), 64'd6);
    chk("t9_z_cnt", 64'(z_cnt), 64'd2);
    do_run(1'b0, 30, 0);
    chk("t9_table_kept", gotv, 64'h07);
    chk("t9_x_again", 64'(x_cnt), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_source_scorer.md
Name: pattern_source_scorer

Overview:
- Stimulus and scoring end of the pattern-predictor interface.
- Drives the actual_pattern bit stream that a predictor such as pattern_predictor_2bit consumes, and samples that predictor's predicted_pattern output every valid cycle.
- Keeps an emitted-bit count (x_cnt) and a correct-prediction count (z_cnt), so the stream can be replayed in hardware instead of by a testbench.
- Two stream sources: a programmable run-length table, or an 8-bit LFSR.

Parameters:
- DEPTH, 8, number of run-length table entries (power of 2).
- LEN_W, 8, width of each run length and of lfsr_len.
- CNT_W, 8, width of x_cnt and z_cnt.
- LFSR_SEED, 8'hA5, LFSR value loaded on start; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  begin a stream; honoured only in IDLE or DONE.
- mode  in  1  0 = run-length table, 1 = LFSR; sampled on start.
- wr_en  in  1  table write strobe; honoured only when not RUN.
- wr_addr  in  $clog2(DEPTH)  table entry index.
- wr_level  in  1  bit value of the entry.
- wr_len  in  LEN_W  run length of the entry, in cycles.
- num_entries  in  $clog2(DEPTH)+1  number of table entries used; sampled on start.
- lfsr_len  in  LEN_W  bits to emit in LFSR mode; sampled on start.
- predicted_pattern  in  1  predictor output for the current bit.
- actual_pattern  out  1  stream bit.
- pattern_valid  out  1  actual_pattern is valid this cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- x_cnt  out  CNT_W  bits emitted since start.
- z_cnt  out  CNT_W  cycles where pattern_valid && predicted_pattern == actual_pattern.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Table entries clear to level 0, len 0.
  - LFSR loads LFSR_SEED.
  - Reset mid-run aborts the run immediately; there is no completion pulse.
- FSM states:
  - IDLE -(start)-> RUN.
  - RUN -(last bit emitted)-> DONE.
  - DONE -(start)-> RUN.
  - start while in RUN is ignored.
- On an accepted start in cycle t:
  - x_cnt, z_cnt, entry pointer and run counter clear.
  - mode, num_entries and lfsr_len are latched.
  - First pattern_valid occurs in cycle t+1.
- Table mode:
  - Entries are emitted in order 0..num_entries-1.
  - Entry k drives actual_pattern=level_k with pattern_valid=1 for len_k consecutive cycles.
  - len_k = 0: the entry is skipped, costing one bubble cycle (pattern_valid=0, actual_pattern holds its last value).
  - Entries are back-to-back; there is no gap between nonzero entries.
  - num_entries = 0: RUN lasts one cycle with pattern_valid=0, then DONE.
  - num_entries > DEPTH is clamped to DEPTH.
- LFSR mode:
  - Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - actual_pattern = lfsr[0]; the LFSR shifts after each valid bit.
  - Emits exactly lfsr_len bits.
  - lfsr_len = 0 behaves like num_entries = 0.
- Scoring:
  - predicted_pattern is sampled in the same cycle as pattern_valid; the predictor output is treated as its guess for the current bit.
  - x_cnt and z_cnt update on the clock edge ending each valid cycle.
  - Both counters saturate at 2^CNT_W-1; the stream continues after saturation.
- DONE:
  - Entered on the edge after the last valid bit.
  - pattern_valid=0, busy=0, done=1.
  - x_cnt and z_cnt hold until the next start.
- Writes:
  - wr_en in IDLE or DONE writes the entry on the clock edge.
  - wr_en in RUN is ignored; table contents are unchanged.
  - A write and a start in the same cycle: the write lands first, and the new entry is used by the run.

Decomposition:
- Package pattern_pkg holds:
  - typedef state_t {IDLE, RUN, DONE}
  - typedef run_entry_t {logic level; logic [LEN_W-1:0] len;}
  - localparam LFSR_TAPS = 8'hB8
  - localparam LFSR_SEED default
- One sub-module, pattern_lfsr8: enable, load, seed, q.
- Table storage, FSM and scoring stay in the top module.

Test Plan:
- Table {0:(0,4), 1:(1,8), 2:(0,4), 3:(1,4), 4:(0,8), 5:(1,4), 6:(0,4)}, num_entries=7, predicted_pattern tied 0 -> 36 valid bits in exactly that sequence; x_cnt=36, z_cnt=20; done rises on cycle t+37.
- Same table, predicted_pattern = actual_pattern delayed one cycle -> x_cnt=36, z_cnt=30 (mismatch only on the 6 transitions).
- Entry 1 len=0, others as scenario 1 -> one bubble cycle between entries 0 and 2; x_cnt=28.
- LFSR mode, lfsr_len=10, predicted tied 1 -> first bits 1,0,1,0,0,1,0,1,... from seed A5; x_cnt=10; z_cnt equals the number of ones emitted.
- Table entry (1,255) twice, predicted tied 1 -> x_cnt and z_cnt saturate at 255; done asserted after 510 valid bits.
- rst low mid-run at bit 5; wr_en during RUN; start during RUN -> immediate IDLE with all outputs 0; the RUN write does not change the table; the RUN start has no effect.
